// File: rtl/rf_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_scoreboard: register file (2R/1W) with per-register busy scoreboard    |
// | and registered outstanding-producer count. Option: RF_BYPASS_EN forwards  |
// | same-cycle write-back data and busy clear onto the read ports.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rf_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG),
  localparam int CW       = AW + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   RNUM1,
  input  logic [AW-1:0]   RNUM2,
  output logic [XLEN-1:0] RDATA1,
  output logic [XLEN-1:0] RDATA2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WEN,
  input  logic [AW-1:0]   WNUM,
  input  logic [XLEN-1:0] WDATA,
  input  logic            ISSUE,
  input  logic [AW-1:0]   INUM,
  input  logic            FLUSH,
  output logic [CW-1:0]   PEND_CNT
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_wr_ok;
  logic            w_is_ok;
  logic            w_inc;
  logic            w_dec;

  // Hard-wired r0 drops both write-back and issue.
  assign w_wr_ok = WEN   && !((ZERO_REG != 0) && (WNUM == '0));
  assign w_is_ok = ISSUE && !((ZERO_REG != 0) && (INUM == '0));

  always_comb begin
    w_pend_nxt = FLUSH ? '0 : r_pend;
    if (w_wr_ok) w_pend_nxt[WNUM] = 1'b0;
    if (w_is_ok) w_pend_nxt[INUM] = 1'b1;
  end

  // Non-flush count delta; an issue colliding with write-back keeps the bit set.
  assign w_inc = w_is_ok && !r_pend[INUM];
  assign w_dec = w_wr_ok && r_pend[WNUM] && !(w_is_ok && (INUM == WNUM));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (FLUSH) r_cnt <= {{AW{1'b0}}, w_is_ok};
      else       r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[WNUM] <= WDATA;
    end
  end

  logic [AW-1:0]   w_rnum  [2];
  logic [XLEN-1:0] w_rdata [2];
  logic            w_busy  [2];

  assign w_rnum[0] = RNUM1;
  assign w_rnum[1] = RNUM2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic w_zero;
    assign w_zero = (ZERO_REG != 0) && (w_rnum[p] == '0);
`ifdef RF_BYPASS_EN
    logic w_hit;
    assign w_hit      = w_wr_ok && (WNUM == w_rnum[p]);
    assign w_rdata[p] = w_zero ? '0 : (w_hit ? WDATA : r_regs[w_rnum[p]]);
    assign w_busy[p]  = !w_zero && (w_hit ? (w_is_ok && (INUM == w_rnum[p]))
                                          : r_pend[w_rnum[p]]);
`else
    assign w_rdata[p] = w_zero ? '0 : r_regs[w_rnum[p]];
    assign w_busy[p]  = !w_zero && r_pend[w_rnum[p]];
`endif
  end

  assign RDATA1   = w_rdata[0];
  assign RDATA2   = w_rdata[1];
  assign BUSY1    = w_busy[0];
  assign BUSY2    = w_busy[1];
  assign PEND_CNT = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_scoreboard: directed + randomized bench with array/popcount model.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rf_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [AW-1:0]   RNUM1 = '0, RNUM2 = '0, WNUM = '0, INUM = '0;
  logic [XLEN-1:0] WDATA = '0;
  logic            WEN = 1'b0, ISSUE = 1'b0, FLUSH = 1'b0;
  logic [XLEN-1:0] RDATA1, RDATA2;
  logic            BUSY1, BUSY2;
  logic [CW-1:0]   PEND_CNT;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .RNUM1(RNUM1), .RNUM2(RNUM2),
    .RDATA1(RDATA1), .RDATA2(RDATA2), .BUSY1(BUSY1), .BUSY2(BUSY2),
    .WEN(WEN), .WNUM(WNUM), .WDATA(WDATA), .ISSUE(ISSUE), .INUM(INUM),
    .FLUSH(FLUSH), .PEND_CNT(PEND_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += m_pend[i];
    return n;
  endfunction

  function automatic bit wr_live();
    return WEN && (WNUM != 0);
  endfunction

  function automatic bit is_live();
    return ISSUE && (INUM != 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int idx);
    if (idx == 0) return '0;
`ifdef RF_BYPASS_EN
    if (wr_live() && WNUM == idx) return WDATA;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(input int idx);
    if (idx == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (wr_live() && WNUM == idx) return is_live() && INUM == idx;
`endif
    return m_pend[idx];
  endfunction

  // Edge semantics: flush clears all, write-back clears its bit, issue sets last.
  function automatic void model_edge();
    if (FLUSH) for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    if (wr_live()) begin
      m_regs[WNUM] = WDATA;
      m_pend[WNUM] = 1'b0;
    end
    if (is_live()) m_pend[INUM] = 1'b1;
  endfunction

  task automatic check_reads(input string tag);
    chk({tag, "_rdata1"}, RDATA1, exp_data(int'(RNUM1)));
    chk({tag, "_rdata2"}, RDATA2, exp_data(int'(RNUM2)));
    chk({tag, "_busy1"}, 32'(BUSY1), 32'(exp_busy(int'(RNUM1))));
    chk({tag, "_busy2"}, 32'(BUSY2), 32'(exp_busy(int'(RNUM2))));
  endtask

  task automatic drive(input bit wen, input int wnum, input logic [XLEN-1:0] wdata,
                       input bit issue, input int inum, input bit flush,
                       input int r1, input int r2);
    WEN = wen; WNUM = AW'(wnum); WDATA = wdata;
    ISSUE = issue; INUM = AW'(inum); FLUSH = flush;
    RNUM1 = AW'(r1); RNUM2 = AW'(r2);
  endtask

  // Entered at negedge with inputs applied; returns at the next negedge.
  task automatic cycle(input string tag);
    #1;
    check_reads({tag, "_pre"});
    @(posedge CLK);
    model_edge();
    #1;
    chk({tag, "_cnt"}, 32'(PEND_CNT), 32'(model_count()));
    check_reads({tag, "_post"});
    @(negedge CLK);
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0, int'(RNUM1), int'(RNUM2));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_cnt", 32'(PEND_CNT), 32'd0);
    chk("reset_rdata", RDATA1, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // 1: reset mid-operation
    drive(1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 5);
    cycle("t1_wr");
    drive(0, 0, '0, 1, 8, 0, 5, 8);
    cycle("t1_iss");
    chk("t1_before_rst", RDATA1, 32'hDEADBEEF);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("t1_rst_rdata", RDATA1, 32'd0);
    chk("t1_rst_cnt", 32'(PEND_CNT), 32'd0);
    drive(1, 5, 32'hDEADBEEF, 1, 5, 1, 5, 8);
    @(posedge CLK);
    #1;
    chk("t1_rst_hold_rdata", RDATA1, 32'd0);
    chk("t1_rst_hold_cnt", 32'(PEND_CNT), 32'd0);
    chk("t1_rst_hold_busy", 32'(BUSY1), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle();

    // 2: r0 write and issue are dropped
    drive(1, 0, 32'h1234, 1, 0, 0, 0, 0);
    cycle("t2");
    chk("t2_r0_data", RDATA1, 32'd0);
    chk("t2_cnt", 32'(PEND_CNT), 32'd0);

    // 3: scoreboard counting
    drive(0, 0, '0, 1, 3, 0, 3, 7); cycle("t3_a"); chk("t3_cnt1", 32'(PEND_CNT), 32'd1);
    drive(0, 0, '0, 1, 7, 0, 3, 7); cycle("t3_b"); chk("t3_cnt2", 32'(PEND_CNT), 32'd2);
    drive(0, 0, '0, 1, 3, 0, 3, 7); cycle("t3_c"); chk("t3_cnt3", 32'(PEND_CNT), 32'd2);
    drive(1, 3, 32'hA5A5A5A5, 0, 0, 0, 3, 7); cycle("t3_wb");
    idle();
    #1;
    chk("t3_wb_cnt", 32'(PEND_CNT), 32'd1);
    chk("t3_wb_busy", 32'(BUSY1), 32'd0);
    chk("t3_wb_data", RDATA1, 32'hA5A5A5A5);
    @(negedge CLK);

    // 4: issue/write-back collision keeps the bit set
    drive(0, 0, '0, 1, 9, 0, 9, 7); cycle("t4_iss");
    drive(1, 9, 32'h55, 1, 9, 0, 9, 7); cycle("t4_col");
    idle();
    #1;
    chk("t4_busy", 32'(BUSY1), 32'd1);
    chk("t4_cnt", 32'(PEND_CNT), 32'd2);
    chk("t4_data", RDATA1, 32'h55);
    @(negedge CLK);

    // 5: flush with concurrent issue
    drive(0, 0, '0, 1, 1, 0, 1, 2); cycle("t5_1");
    drive(0, 0, '0, 1, 2, 0, 1, 2); cycle("t5_2");
    drive(0, 0, '0, 1, 4, 0, 4, 6); cycle("t5_4");
    drive(0, 0, '0, 1, 6, 1, 4, 6); cycle("t5_fl");
    idle();
    #1;
    chk("t5_busy4", 32'(BUSY1), 32'd0);
    chk("t5_busy6", 32'(BUSY2), 32'd1);
    chk("t5_cnt", 32'(PEND_CNT), 32'd1);
    @(negedge CLK);

    // 6: same-cycle read of the write-back target
    drive(1, 12, 32'hCAFE0001, 0, 0, 0, 12, 6);
    #1;
`ifdef RF_BYPASS_EN
    chk("t6_same_cycle", RDATA1, 32'hCAFE0001);
`else
    chk("t6_same_cycle", RDATA1, 32'd0);
`endif
    @(negedge CLK);
    model_edge();
    chk("t6_after", RDATA1, 32'hCAFE0001);
    idle();

    // Randomized traffic; small index range raises collision rate
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom(),
            $urandom_range(0, 1), $urandom_range(0, 15), ($urandom_range(0, 19) == 0),
            $urandom_range(0, 15), $urandom_range(0, NREG - 1));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
